// File: rtl/spmv_sram_responder_if.sv
// Host-side access bus for spmv_sram_responder: address/strobes/write data in, read data out.
interface spmv_sram_responder_if #(
  parameter int unsigned DATA_LEN     = 32,
  parameter int unsigned N            = 8,
  parameter int unsigned ADDRESS_SIZE = 4
);
  localparam int unsigned W = DATA_LEN * N;

  logic [ADDRESS_SIZE-1:0] i_address;
  logic                    i_clken;
  logic                    i_chipselect;
  logic                    i_write;
  logic [W-1:0]            i_writedata;
  logic [W/8-1:0]          i_byteenable;
  logic [W-1:0]            o_readdata;

  modport master (
    output i_address, i_clken, i_chipselect, i_write, i_writedata, i_byteenable,
    input  o_readdata
  );

  modport slave (
    input  i_address, i_clken, i_chipselect, i_write, i_writedata, i_byteenable,
    output o_readdata
  );
endinterface

// File: rtl/spmv_sram_responder.sv
// Word-wide SRAM responder: zero-fills all words after reset, then serves byte-masked accesses.
// Define SPMV_SRAM_RDW_NEW_DATA_EN to return the merged new word on a write (default: old word).
module spmv_sram_responder #(
  parameter int unsigned DATA_LEN     = 32,
  parameter int unsigned N            = 8,
  parameter int unsigned ADDRESS_SIZE = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  spmv_sram_responder_if.slave     bus,
  output logic                     o_ready,
  output logic [15:0]              o_wr_count
);
  localparam int unsigned W     = DATA_LEN * N;
  localparam int unsigned Depth = 1 << ADDRESS_SIZE;
  localparam int unsigned BeW   = W / 8;

  typedef enum logic {StClear, StServe} state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] clr_cnt_q, clr_cnt_d;
  logic [W-1:0]            rdata_q, rdata_d;
  logic [15:0]             wr_cnt_q, wr_cnt_d;
  logic [W-1:0]            mem_q [Depth];

  logic [W-1:0]            old_word, merged_word, mem_wdata;
  logic [ADDRESS_SIZE-1:0] mem_waddr;
  logic                    mem_we;

  assign old_word = mem_q[bus.i_address];

  always_comb begin
    merged_word = old_word;
    for (int k = 0; k < BeW; k++) begin
      if (bus.i_byteenable[k]) merged_word[8*k +: 8] = bus.i_writedata[8*k +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rdata_d   = rdata_q;
    wr_cnt_d  = wr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.i_address;
    mem_wdata = merged_word;
    unique case (state_q)
      StClear: begin
        // Host accesses and i_clken are ignored while zero-filling.
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {ADDRESS_SIZE{1'b1}}) state_d = StServe;
      end
      StServe: begin
        if (bus.i_clken && bus.i_chipselect) begin
          rdata_d = old_word;
          if (bus.i_write) begin
            mem_we = 1'b1;
            if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
`ifdef SPMV_SRAM_RDW_NEW_DATA_EN
            rdata_d = merged_word;
`else
            rdata_d = old_word;
`endif
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
      rdata_q   <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata_q   <= rdata_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Storage has no reset; the CLEAR sweep provides the zero contents.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.o_readdata = rdata_q;
  assign o_ready        = (state_q == StServe);
  assign o_wr_count     = wr_cnt_q;
endmodule

// File: tb/tb_spmv_sram_responder.sv
// Self-checking bench for spmv_sram_responder: directed vector table, reset sequences, random vs model.
module tb_spmv_sram_responder;
  localparam int unsigned DL = 32;
  localparam int unsigned NE = 8;
  localparam int unsigned AS = 4;
  localparam int unsigned W  = DL * NE;
  localparam int unsigned D  = 1 << AS;
  localparam int unsigned BW = W / 8;
`ifdef SPMV_SRAM_RDW_NEW_DATA_EN
  localparam bit RdwNew = 1'b1;
`else
  localparam bit RdwNew = 1'b0;
`endif

  typedef struct {
    string         name;
    logic          wr;
    logic          cs;
    logic          ce;
    logic [AS-1:0] addr;
    logic [W-1:0]  wdata;
    logic [BW-1:0] be;
    logic [W-1:0]  exp_rd;
    logic [15:0]   exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [15:0] wr_count;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  spmv_sram_responder_if #(.DATA_LEN(DL), .N(NE), .ADDRESS_SIZE(AS)) bus ();

  spmv_sram_responder #(.DATA_LEN(DL), .N(NE), .ADDRESS_SIZE(AS)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_ready    (ready),
    .o_wr_count (wr_count)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic cs, input logic ce, input logic [AS-1:0] a,
                       input logic [W-1:0] wd, input logic [BW-1:0] be);
    bus.i_write      = wr;
    bus.i_chipselect = cs;
    bus.i_clken      = ce;
    bus.i_address    = a;
    bus.i_writedata  = wd;
    bus.i_byteenable = be;
  endtask

  // Pulse reset (optionally aborting a clear part-way), then check the 16-cycle not-ready window.
  task automatic reset_and_check(input int abort_after);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (abort_after > 0) begin
      repeat (abort_after) @(negedge clk);
      chk("ready_mid_clear", {{(W-1){1'b0}}, ready}, '0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    chk("rdata_after_reset", bus.o_readdata, '0);
    chk("cnt_after_reset", {{(W-16){1'b0}}, wr_count}, '0);
    for (int i = 0; i < D; i++) begin
      chk("ready_low_in_clear", {{(W-1){1'b0}}, ready}, '0);
      @(negedge clk);
    end
    chk("ready_high_after_clear", {{(W-1){1'b0}}, ready}, {{(W-1){1'b0}}, 1'b1});
  endtask

  function automatic vec_t mk(input string n, input logic wr, input logic cs, input logic ce,
                              input logic [AS-1:0] a, input logic [W-1:0] wd,
                              input logic [BW-1:0] be, input logic [W-1:0] er,
                              input logic [15:0] ec);
    vec_t v;
    v.name = n; v.wr = wr; v.cs = cs; v.ce = ce; v.addr = a;
    v.wdata = wd; v.be = be; v.exp_rd = er; v.exp_cnt = ec;
    return v;
  endfunction

  logic [W-1:0] model_mem [D];
  logic [W-1:0] model_rd;
  logic [15:0]  model_cnt;

  initial begin
    vec_t         tbl [$];
    logic [W-1:0] a5, ones, hi_ones, zero;
    zero    = '0;
    ones    = '1;
    a5      = {8{32'hA5A5_A5A5}};
    hi_ones = {{(W-32){1'b1}}, 32'h0};

    tbl.push_back(mk("wr3_a5",      1, 1, 1, 4'd3, a5,   '1,        RdwNew ? a5 : zero,       16'd1));
    tbl.push_back(mk("rd3",         0, 1, 1, 4'd3, zero, '0,        a5,                       16'd1));
    tbl.push_back(mk("wr5_ones",    1, 1, 1, 4'd5, ones, '1,        RdwNew ? ones : zero,     16'd2));
    tbl.push_back(mk("wr5_low0",    1, 1, 1, 4'd5, zero, 32'h0000000F, RdwNew ? hi_ones : ones, 16'd3));
    tbl.push_back(mk("rd5_merge",   0, 1, 1, 4'd5, zero, '0,        hi_ones,                  16'd3));
    tbl.push_back(mk("wr7_old1",    1, 1, 1, 4'd7, W'(1), '1,       RdwNew ? W'(1) : zero,    16'd4));
    tbl.push_back(mk("wr7_new2",    1, 1, 1, 4'd7, W'(2), '1,       RdwNew ? W'(2) : W'(1),   16'd5));
    tbl.push_back(mk("wr3_clken0",  1, 1, 0, 4'd3, zero, '1,        RdwNew ? W'(2) : W'(1),   16'd5));
    tbl.push_back(mk("wr3_cs0",     1, 0, 1, 4'd3, zero, '1,        RdwNew ? W'(2) : W'(1),   16'd5));
    tbl.push_back(mk("rd3_intact",  0, 1, 1, 4'd3, zero, '0,        a5,                       16'd5));
    tbl.push_back(mk("rd7",         0, 1, 1, 4'd7, zero, '0,        W'(2),                    16'd5));
    tbl.push_back(mk("wr9_nomask",  1, 1, 1, 4'd9, ones, '0,        zero,                     16'd6));
    tbl.push_back(mk("rd9",         0, 1, 1, 4'd9, zero, '0,        zero,                     16'd6));
    tbl.push_back(mk("rd5_cs0_hold",0, 0, 1, 4'd5, zero, '0,        zero,                     16'd6));

    // Power-up reset and clear, then every word must read zero.
    reset_and_check(0);
    for (int a = 0; a < D; a++) begin
      drive(1'b0, 1'b1, 1'b1, AS'(a), '0, '0);
      @(negedge clk);
      chk($sformatf("clear_rd%0d", a), bus.o_readdata, '0);
    end
    chk("cnt_after_clear", {{(W-16){1'b0}}, wr_count}, '0);

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].cs, tbl[i].ce, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      @(negedge clk);
      chk({tbl[i].name, "_rd"}, bus.o_readdata, tbl[i].exp_rd);
      chk({tbl[i].name, "_cnt"}, {{(W-16){1'b0}}, wr_count}, {{(W-16){1'b0}}, tbl[i].exp_cnt});
    end

    // Reset during SERVE with live data, then a reset that aborts the clear half-way.
    drive(1'b1, 1'b1, 1'b1, 4'd2, {8{32'hDEAD_BEEF}}, '1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    reset_and_check(5);
    drive(1'b0, 1'b1, 1'b1, 4'd2, '0, '0);
    @(negedge clk);
    chk("rd2_after_reset", bus.o_readdata, '0);
    chk("cnt_zero_after_reset", {{(W-16){1'b0}}, wr_count}, '0);

    for (int a = 0; a < D; a++) model_mem[a] = '0;
    model_rd  = '0;
    model_cnt = 16'd0;

    for (int it = 0; it < 400; it++) begin
      logic          wr, cs, ce;
      logic [AS-1:0] a;
      logic [W-1:0]  wd, merged;
      logic [BW-1:0] be;
      wr = 1'($urandom_range(0, 1));
      cs = ($urandom_range(0, 3) != 0);
      ce = ($urandom_range(0, 3) != 0);
      a  = AS'($urandom_range(0, D - 1));
      for (int k = 0; k < W / 32; k++) wd[32*k +: 32] = $urandom;
      be = $urandom;
      if (it % 7 == 0) be = '1;
      drive(wr, cs, ce, a, wd, be);
      if (cs && ce) begin
        merged = model_mem[a];
        for (int k = 0; k < BW; k++) if (be[k]) merged[8*k +: 8] = wd[8*k +: 8];
        if (wr) begin
          model_rd     = RdwNew ? merged : model_mem[a];
          model_mem[a] = merged;
          if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        end else begin
          model_rd = model_mem[a];
        end
      end
      @(negedge clk);
      chk("rand_rd", bus.o_readdata, model_rd);
      chk("rand_cnt", {{(W-16){1'b0}}, wr_count}, {{(W-16){1'b0}}, model_cnt});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/spmv_sram_responder.md
SPMV_SRAM_RESPONDER -- requirements
Module: spmv_sram_responder

Interface
REQ-001 SHALL provide parameter DATA_LEN, default 32, meaning element width in bits.
REQ-002 SHALL provide parameter N, default 8, meaning elements per memory word; word width W = DATA_LEN*N (256).
REQ-003 SHALL provide parameter ADDRESS_SIZE, default 4, meaning address bits; depth D = 2^ADDRESS_SIZE (16 words).
REQ-004 SHALL have port i_clk, input, 1, sole clock, all logic on rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port i_address, input, ADDRESS_SIZE, word address.
REQ-007 SHALL have port i_clken, input, 1, clock enable; 0 freezes the access path.
REQ-008 SHALL have port i_chipselect, input, 1, access select.
REQ-009 SHALL have port i_write, input, 1, write request (1) / read request (0).
REQ-010 SHALL have port i_writedata, input, W, write data.
REQ-011 SHALL have port i_byteenable, input, W/8 (32), per-byte write mask; bit k covers bits [8k+7:8k].
REQ-012 SHALL have port o_readdata, output, W, registered read data.
REQ-013 SHALL have port o_ready, output, 1, high when the initial clear is complete and accesses are serviced.
REQ-014 SHALL have port o_wr_count, output, 16, saturating count of accepted writes.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR, then SERVE.
REQ-016 In CLEAR, SHALL write all-zero words to addresses 0..D-1 using an ADDRESS_SIZE-bit counter, one word per cycle, ignoring i_clken.
REQ-017 SHALL hold o_ready=0 in CLEAR and enter SERVE the cycle after address D-1 is cleared (D cycles after reset release), with o_ready=1 from that cycle onward.
REQ-018 In CLEAR, SHALL ignore all host accesses, hold o_readdata=0, and leave o_wr_count unchanged.
REQ-019 An access is accepted in SERVE when i_clken=1 and i_chipselect=1.
REQ-020 An accepted write SHALL update only the bytes whose i_byteenable bit is 1; all other bytes keep their value; an all-zero mask writes nothing but still counts.
REQ-021 An accepted access (read or write) SHALL load o_readdata on the next rising edge with the word at i_address (read latency 1).
REQ-022 When i_clken=0 or i_chipselect=0, SHALL perform no write and hold o_readdata unchanged.
REQ-023 Back-to-back accesses SHALL be supported every cycle with no stall and no ready handshake beyond o_ready.
REQ-024 o_wr_count SHALL increment by 1 per accepted write and saturate at 16'hFFFF.
REQ-025 Out-of-range addresses do not exist (i_address spans exactly D words); no wrap logic is needed.

Reset
REQ-026 Asserting i_rst SHALL, on the next rising edge: set the FSM to CLEAR, the clear counter to 0, o_readdata to 0, o_ready to 0, and o_wr_count to 0.
REQ-027 Reset asserted mid-CLEAR or mid-SERVE SHALL restart the full D-cycle clear from address 0; memory contents are then all zero.

Configuration
REQ-028 Macro SPMV_SRAM_RDW_NEW_DATA_EN SHALL select read-during-write behaviour for an accepted write.
REQ-029 With SPMV_SRAM_RDW_NEW_DATA_EN defined, o_readdata after an accepted write SHALL equal the merged new word (enabled bytes from i_writedata, other bytes old).
REQ-030 Without SPMV_SRAM_RDW_NEW_DATA_EN, o_readdata after an accepted write SHALL equal the old word before the write.

Verification
REQ-031 Reset 1 cycle, release -> o_ready=0 for 16 cycles then 1; read all 16 addresses -> every o_readdata = 0, o_wr_count=0.
REQ-032 Write addr 3 data 256'h...A5A5 with byteenable 32'hFFFFFFFF, next cycle read addr 3 -> o_readdata = written word one cycle after read; o_wr_count=1.
REQ-033 Write addr 5 all-ones, then write addr 5 all-zeros with byteenable 32'h0000000F, read addr 5 -> low 32 bits 0, upper 224 bits all ones.
REQ-034 Write addr 7 old=1 then write addr 7 new=2 -> o_readdata after the second write = 2 with macro, 1 without.
REQ-035 Accepted write with i_clken=0, then with i_chipselect=0 -> memory unchanged, o_readdata held, o_wr_count unchanged.
REQ-036 Write addr 2 nonzero, assert i_rst at SERVE cycle 4 -> o_ready low 16 cycles, addr 2 reads 0, o_wr_count=0.
